// File: rtl/ode_ram_pkg.sv
// Shared constants and types for the ODE solver RAM port arbiter.
// The BURST state only exists when RAM_ARB_BURST_EN is defined.
package ode_ram_pkg;

  localparam int NUM_REQ           = 3;
  localparam int REQ_CORE          = 0;
  localparam int REQ_INTERP        = 1;
  localparam int REQ_HOST          = 2;
  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_ADDRESS_WIDTH = 10;
  localparam int DEF_MAX_BURST     = 16;

`ifdef RAM_ARB_BURST_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2
  } arb_state_e;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
`endif

  // Round-robin pointer to use after a one-hot winner: the requester after it.
  function automatic logic [1:0] rr_next(input logic [NUM_REQ-1:0] onehot);
    logic [1:0] ptr;
    case (onehot)
      3'b001:  ptr = 2'd1;
      3'b010:  ptr = 2'd2;
      3'b100:  ptr = 2'd0;
      default: ptr = 2'd0;
    endcase
    return ptr;
  endfunction

endpackage

// File: rtl/rr_picker3.sv
// Three-way round-robin picker: first set req bit at or after rr_ptr wins.
module rr_picker3
  import ode_ram_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  // Priority search rotated to start at rr_ptr.
  always_comb begin
    winner = 3'b000;
    case (rr_ptr)
      2'd1: begin
        if (req[1])      winner = 3'b010;
        else if (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
        else             winner = 3'b000;
      end
      2'd2: begin
        if (req[2])      winner = 3'b100;
        else if (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else             winner = 3'b000;
      end
      default: begin
        if (req[0])      winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
        else             winner = 3'b000;
      end
    endcase
  end

  assign valid = |winner;

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates three requesters onto one async-read / sync-write RAM port.
// Optional locked bursts are compiled in with RAM_ARB_BURST_EN.
module ram_port_arbiter
  import ode_ram_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int MAX_BURST     = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ-1:0]       wr,
  input  logic [ADDRESS_WIDTH-1:0] addr_0,
  input  logic [ADDRESS_WIDTH-1:0] addr_1,
  input  logic [ADDRESS_WIDTH-1:0] addr_2,
  input  logic [DATA_WIDTH-1:0]    wdata_0,
  input  logic [DATA_WIDTH-1:0]    wdata_1,
  input  logic [DATA_WIDTH-1:0]    wdata_2,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_data_write,
  output logic                     ram_WR_signal,
  input  logic [DATA_WIDTH-1:0]    ram_data_read
);

  arb_state_e         state_r, state_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s;
  logic [1:0]         rr_ptr_r, rr_ptr_s;
  logic [NUM_REQ-1:0] pick_req_s;
  logic [NUM_REQ-1:0] winner_s;
  logic               valid_s;

`ifdef RAM_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] burst_cnt_r, burst_cnt_s;
  logic             lock_hit_s;
  logic             cap_s;
`else
  logic             unused_lock_s;
  assign unused_lock_s = ^{lock, MAX_BURST[0]};
`endif

  rr_picker3 u_picker (
    .req    (pick_req_s),
    .rr_ptr (rr_ptr_r),
    .winner (winner_s),
    .valid  (valid_s)
  );

  // Next grant decision: hold a locked burst or rearbitrate among live requests.
  always_comb begin
    state_s    = IDLE;
    gnt_s      = 3'b000;
    rr_ptr_s   = rr_ptr_r;
    pick_req_s = req;
`ifdef RAM_ARB_BURST_EN
    burst_cnt_s = '0;
    lock_hit_s  = 1'b0;
    cap_s       = 1'b0;
    case (state_r)
      GRANT, BURST: begin
        lock_hit_s = |(gnt_r & lock & req);
        cap_s      = (burst_cnt_r == CNT_W'(MAX_BURST - 1));
      end
      default: begin
        lock_hit_s = 1'b0;
        cap_s      = 1'b0;
      end
    endcase
    // A burst that reached its cap sits out exactly this one decision.
    if (lock_hit_s && cap_s) begin
      pick_req_s = req & ~gnt_r;
    end else begin
      pick_req_s = req;
    end
    if (lock_hit_s && !cap_s) begin
      state_s     = BURST;
      gnt_s       = gnt_r;
      rr_ptr_s    = rr_next(gnt_r);
      burst_cnt_s = burst_cnt_r + CNT_W'(1);
    end else if (valid_s) begin
      state_s  = GRANT;
      gnt_s    = winner_s;
      rr_ptr_s = rr_next(winner_s);
    end else begin
      state_s = IDLE;
      gnt_s   = 3'b000;
    end
`else
    case (state_r)
      IDLE, GRANT: begin
        if (valid_s) begin
          state_s  = GRANT;
          gnt_s    = winner_s;
          rr_ptr_s = rr_next(winner_s);
        end else begin
          state_s = IDLE;
          gnt_s   = 3'b000;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 3'b000;
      end
    endcase
`endif
  end

  // Arbiter state registers; reset cancels any grant in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      gnt_r    <= 3'b000;
      rr_ptr_r <= 2'd0;
`ifdef RAM_ARB_BURST_EN
      burst_cnt_r <= '0;
`endif
    end else begin
      state_r  <= state_s;
      gnt_r    <= gnt_s;
      rr_ptr_r <= rr_ptr_s;
`ifdef RAM_ARB_BURST_EN
      burst_cnt_r <= burst_cnt_s;
`endif
    end
  end

  // RAM port mux driven by the registered grant.
  always_comb begin
    ram_address    = '0;
    ram_data_write = '0;
    case (gnt_r)
      3'b001: begin
        ram_address    = addr_0;
        ram_data_write = wdata_0;
      end
      3'b010: begin
        ram_address    = addr_1;
        ram_data_write = wdata_1;
      end
      3'b100: begin
        ram_address    = addr_2;
        ram_data_write = wdata_2;
      end
      default: begin
        ram_address    = '0;
        ram_data_write = '0;
      end
    endcase
  end

  assign gnt           = gnt_r;
  assign ram_WR_signal = |(gnt_r & wr);
  assign rdata         = ram_data_read;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural RAM.
// Burst expectations follow RAM_ARB_BURST_EN.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  lock = 3'b000;
  logic [2:0]  wr = 3'b000;
  logic [9:0]  addr_0 = 10'd0, addr_1 = 10'd0, addr_2 = 10'd0;
  logic [63:0] wdata_0 = 64'd0, wdata_1 = 64'd0, wdata_2 = 64'd0;
  logic [2:0]  gnt;
  logic [63:0] rdata;
  logic [9:0]  ram_address;
  logic [63:0] ram_data_write;
  logic        ram_WR_signal;
  logic [63:0] ram_data_read;

  logic [63:0] mem [0:1023];
  logic        preload_en = 1'b0;
  logic [9:0]  preload_addr = 10'd0;
  logic [63:0] preload_data = 64'd0;

  int checks = 0;
  int failures = 0;

  ram_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .lock           (lock),
    .wr             (wr),
    .addr_0         (addr_0),
    .addr_1         (addr_1),
    .addr_2         (addr_2),
    .wdata_0        (wdata_0),
    .wdata_1        (wdata_1),
    .wdata_2        (wdata_2),
    .gnt            (gnt),
    .rdata          (rdata),
    .ram_address    (ram_address),
    .ram_data_write (ram_data_write),
    .ram_WR_signal  (ram_WR_signal),
    .ram_data_read  (ram_data_read)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read, synchronous write, plus bench preload.
  assign ram_data_read = mem[ram_address];
  always @(posedge clk) begin
    if (ram_WR_signal) mem[ram_address] <= ram_data_write;
    else if (preload_en) mem[preload_addr] <= preload_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    req = 3'b000; wr = 3'b000; lock = 3'b000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [63:0] d);
    preload_addr = a; preload_data = d; preload_en = 1'b1;
    tick();
    preload_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 3'b111; wr = 3'b111;
    tick();
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    checks++;
    if (ram_WR_signal !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b expected 0", ram_WR_signal); end
    checks++;
    if (ram_address !== 10'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", ram_address); end
    apply_reset();
  endtask

  task automatic test_write;
    apply_reset();
    req = 3'b001; wr = 3'b001; addr_0 = 10'd5; wdata_0 = 64'hAB;
    tick();
    checks++;
    if (gnt !== 3'b001) begin failures++; $display("FAIL write_gnt: got %b expected 001", gnt); end
    checks++;
    if (ram_WR_signal !== 1'b1) begin failures++; $display("FAIL write_strobe: got %b expected 1", ram_WR_signal); end
    checks++;
    if (ram_address !== 10'd5) begin failures++; $display("FAIL write_addr: got %0d expected 5", ram_address); end
    req = 3'b000;
    tick();
    wr = 3'b000;
    checks++;
    if (mem[5] !== 64'hAB) begin failures++; $display("FAIL write_mem: got %h expected ab", mem[5]); end
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL write_idle: got %b expected 000", gnt); end
    checks++;
    if (ram_address !== 10'd0) begin failures++; $display("FAIL idle_addr: got %0d expected 0", ram_address); end
  endtask

  task automatic test_rotation;
    logic [2:0] exp_rot [6];
    exp_rot = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    apply_reset();
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (gnt !== exp_rot[i]) begin failures++; $display("FAIL rotation[%0d]: got %b expected %b", i, gnt, exp_rot[i]); end
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_back_to_back;
    apply_reset();
    req = 3'b011;
    tick();
    checks++;
    if (gnt !== 3'b001) begin failures++; $display("FAIL b2b_first: got %b expected 001", gnt); end
    req = 3'b010;
    tick();
    checks++;
    if (gnt !== 3'b010) begin failures++; $display("FAIL b2b_second: got %b expected 010", gnt); end
    req = 3'b000;
    tick();
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL b2b_release: got %b expected 000", gnt); end
  endtask

  task automatic test_read;
    apply_reset();
    preload(10'd7, 64'h1234);
    req = 3'b010; wr = 3'b000; addr_1 = 10'd7;
    tick();
    checks++;
    if (gnt !== 3'b010) begin failures++; $display("FAIL read_gnt: got %b expected 010", gnt); end
    checks++;
    if (rdata !== 64'h1234) begin failures++; $display("FAIL read_data: got %h expected 1234", rdata); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid_grant;
    apply_reset();
    preload(10'd9, 64'h55);
    req = 3'b100; wr = 3'b100; addr_2 = 10'd9; wdata_2 = 64'hDEAD;
    tick();
    checks++;
    if (gnt !== 3'b100) begin failures++; $display("FAIL midrst_pre_gnt: got %b expected 100", gnt); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL midrst_gnt: got %b expected 000", gnt); end
    checks++;
    if (ram_WR_signal !== 1'b0) begin failures++; $display("FAIL midrst_wr: got %b expected 0", ram_WR_signal); end
    tick();
    checks++;
    if (mem[9] !== 64'h55) begin failures++; $display("FAIL midrst_mem: got %h expected 55", mem[9]); end
    rst_n = 1'b1; wr = 3'b000; req = 3'b111;
    tick();
    checks++;
    if (gnt !== 3'b001) begin failures++; $display("FAIL midrst_restart: got %b expected 001", gnt); end
    req = 3'b000;
    tick();
  endtask

  task automatic test_burst;
    apply_reset();
    req = 3'b111; lock = 3'b001;
`ifdef RAM_ARB_BURST_EN
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (gnt !== 3'b001) begin failures++; $display("FAIL burst_hold[%0d]: got %b expected 001", i, gnt); end
    end
    tick();
    checks++;
    if (gnt !== 3'b010) begin failures++; $display("FAIL burst_cap: got %b expected 010", gnt); end
`else
    begin
      logic [2:0] exp_plain [3];
      exp_plain = '{3'b001, 3'b010, 3'b100};
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++;
        if (gnt !== exp_plain[i]) begin failures++; $display("FAIL lock_ignored[%0d]: got %b expected %b", i, gnt, exp_plain[i]); end
      end
    end
`endif
    req = 3'b000; lock = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_rotation();
    test_back_to_back();
    test_read();
    test_reset_mid_grant();
    test_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the RAM word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 10, the U-memory port address width.
REQ-003 SHALL have parameter MAX_BURST, default 16, the maximum consecutive locked grants.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port req, input, 3, the per-requester access request (0 = solver core, 1 = interpolator, 2 = host loader).
REQ-007 SHALL have port lock, input, 3, the per-requester burst-hold request.
REQ-008 SHALL have port wr, input, 3, the per-requester write strobe.
REQ-009 SHALL have ports addr_0/addr_1/addr_2, input, ADDRESS_WIDTH each, the requester addresses.
REQ-010 SHALL have ports wdata_0/wdata_1/wdata_2, input, DATA_WIDTH each, the requester write data.
REQ-011 SHALL have port gnt, output, 3, the one-hot-or-zero registered grant; a high bit marks that requester's access cycle.
REQ-012 SHALL have port rdata, output, DATA_WIDTH, the RAM read data, broadcast to all requesters.
REQ-013 SHALL have ports ram_address (output, ADDRESS_WIDTH), ram_data_write (output, DATA_WIDTH), ram_WR_signal (output, 1) and ram_data_read (input, DATA_WIDTH), which drive one asynchronous-read, synchronous-write RAM port.

Function
REQ-014 SHALL use FSM states IDLE and GRANT, plus BURST when the burst feature is compiled in.
REQ-015 In IDLE with req nonzero, SHALL select a winner round-robin, starting the search at rr_ptr, and register it into gnt (one-cycle latency from req to gnt).
REQ-016 SHALL combinationally route the granted requester's addr/wdata to ram_address/ram_data_write; with no grant, SHALL drive ram_address and ram_data_write to 0.
REQ-017 SHALL drive ram_WR_signal = |(gnt & wr), so a write commits at the end of the grant cycle.
REQ-018 SHALL drive rdata = ram_data_read at all times; rdata is valid for the granted requester during its grant cycle.
REQ-019 After each granted cycle, SHALL set rr_ptr to (winner+1) mod 3.
REQ-020 In GRANT, SHALL rearbitrate among the current req for the next cycle; back-to-back grants to different requesters SHALL be allowed with no idle cycle.
REQ-021 SHALL return to IDLE with gnt = 0 when req is 0.
REQ-022 SHALL ignore req bits deasserted in the same cycle as a grant decision; a requester SHALL hold req until it sees its gnt bit.
REQ-023 SHALL serve every continuously requesting requester within 3 grant cycles (no starvation).

Reset
REQ-024 On rst_n low, SHALL asynchronously force gnt = 0, state = IDLE, rr_ptr = 0, burst counter = 0 and ram_WR_signal = 0.
REQ-025 If reset asserts during a grant cycle, no write SHALL occur; after rst_n rises, arbitration SHALL restart from requester 0.

Configuration
REQ-026 With macro RAM_ARB_BURST_EN defined: if the granted requester holds lock and req, SHALL keep the grant (state BURST) and count consecutive grants; at MAX_BURST grants it SHALL force rearbitration excluding that requester for one decision, and the counter SHALL clear on any grant change.
REQ-027 Without RAM_ARB_BURST_EN: the lock port SHALL be present but ignored, and the BURST state and counter SHALL not exist.

Structure
REQ-028 Package ode_ram_pkg SHALL hold the requester-ID constants (REQ_CORE=0, REQ_INTERP=1, REQ_HOST=2), the NUM_REQ=3 constant, the FSM state typedef and the default widths.
REQ-029 The round-robin selection SHALL be the sub-module rr_picker3 (inputs req and rr_ptr; outputs one-hot winner and valid).

Verification
REQ-030 Bench SHALL check: req=3'b001, wr=1, addr_0=5, wdata_0=0xAB, one cycle -> gnt=001 next cycle, ram_WR_signal=1, RAM[5]=0xAB after that edge.
REQ-031 Bench SHALL check: all req held for 6 cycles after reset -> gnt sequence 001,010,100,001,010,100.
REQ-032 Bench SHALL check: RAM[7]=0x1234, req=3'b010, addr_1=7, wr=0 -> rdata=0x1234 while gnt=010.
REQ-033 Bench SHALL check: rst_n pulsed low while gnt=100 and wr_2=1 -> gnt=0 immediately, RAM content unchanged, first grant after reset goes to requester 0.
REQ-034 Bench SHALL check, with RAM_ARB_BURST_EN: req=111, lock_0=1 held -> 16 consecutive gnt=001, then gnt=010.
REQ-035 Bench SHALL check, without RAM_ARB_BURST_EN, the same stimulus as REQ-034 -> plain rotation 001,010,100.
